// File: rtl/imem_loader_pkg.sv
// Shared types and sizing constants for the instruction-memory program loader.
package imem_loader_pkg;

    localparam int DEF_MEM_BYTES = 512;
    localparam int MAX_WORDS     = DEF_MEM_BYTES / 4;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        LOAD,
        CHECK,
        DONE,
        ERROR
    } state_t;

    function automatic int words_for(input int mem_bytes);
        return mem_bytes / 4;
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs accepted stream bytes MSB-first into 32-bit words and registers each
// completed word together with a one-cycle write strobe.
module byte_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic        word_last,
    output logic        word_we,
    output logic [31:0] word_data
);

    logic [1:0]  byte_cnt;
    logic [23:0] shift_q;

    // High in the cycle the 4th byte of a word is being accepted.
    assign word_last = shift_en && (byte_cnt == 2'd3);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            byte_cnt  <= '0;
            shift_q   <= '0;
            word_we   <= 1'b0;
            word_data <= '0;
        end else begin
            word_we <= 1'b0;
            if (clear) begin
                byte_cnt <= '0;
            end else if (shift_en) begin
                shift_q  <= {shift_q[15:0], byte_in};
                byte_cnt <= byte_cnt + 2'd1;
                if (byte_cnt == 2'd3) begin
                    word_data <= {shift_q, byte_in};
                    word_we   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Length-prefixed byte-stream loader for instruction memory; holds the CPU
// until a complete image is written. Define IMEM_LOADER_CHECKSUM_EN to expect
// a trailing XOR checksum byte after the payload.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W    = 9,
    parameter int MEM_BYTES = DEF_MEM_BYTES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    localparam int WORDS_MAX = words_for(MEM_BYTES);
    localparam int WCNT_W    = $clog2(WORDS_MAX + 1);

    state_t              state, state_next;
    logic [7:0]          len_hi;
    logic [15:0]         len;
    logic [WCNT_W-1:0]   words_left;
    logic                accept;
    logic                start_go;
    logic                word_last;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]          csum;
`endif

    assign byte_ready = (state == LEN_HI) || (state == LEN_LO) ||
                        (state == LOAD)   || (state == CHECK);
    assign accept     = byte_valid && byte_ready;
    assign start_go   = start && ((state == IDLE) || (state == DONE) || (state == ERROR));
    assign len        = {len_hi, byte_in};
    assign cpu_hold   = (state != DONE);
    assign done       = (state == DONE);
    assign error      = (state == ERROR);

    byte_packer u_packer (
        .clk      (clk),
        .reset    (reset),
        .clear    (start_go),
        .shift_en (accept && (state == LOAD)),
        .byte_in  (byte_in),
        .word_last(word_last),
        .word_we  (mem_we),
        .word_data(mem_data)
    );

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: state_next gets its default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (start) state_next = LEN_HI;
            LEN_HI: if (accept) state_next = LEN_LO;
            LEN_LO: if (accept) begin
                if (len == 16'd0)                    state_next = DONE;
                else if (len > 16'(WORDS_MAX))       state_next = ERROR;
                else                                 state_next = LOAD;
            end
            LOAD: if (word_last && words_left == WCNT_W'(1)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state_next = CHECK;
`else
                state_next = DONE;
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK: if (accept) state_next = (byte_in == csum) ? DONE : ERROR;
`endif
            DONE, ERROR: if (start) state_next = LEN_HI;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            len_hi     <= '0;
            words_left <= '0;
            mem_addr   <= '0;
        end else begin
            if (accept && state == LEN_HI) len_hi <= byte_in;
            if (accept && state == LEN_LO)  words_left <= len[WCNT_W-1:0];
            else if (word_last)             words_left <= words_left - WCNT_W'(1);
            // A new load restarts at address 0 even if the final write is in flight.
            if (start_go)    mem_addr <= '0;
            else if (mem_we) mem_addr <= mem_addr + ADDR_W'(4);
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (!reset)                          csum <= '0;
        else if (start_go)                   csum <= '0;
        else if (accept && state == LOAD)    csum <= csum ^ byte_in;
    end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: cycle-accurate vector table plus
// directed multi-cycle sequences (stall, mid-load reset, checksum build).
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic        mem_we;
    logic [8:0]  mem_addr;
    logic [31:0] mem_data;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int n_checks = 0;
    int n_fail   = 0;
    int we_count = 0;

    typedef struct {
        logic        st;
        logic        vl;
        logic [7:0]  b;
        logic        rdy;
        logic        we;
        logic [8:0]  addr;
        logic [31:0] data;
        logic        hold;
        logic        dn;
        logic        er;
    } vec_t;

    vec_t vecs[$];

    imem_loader #(.ADDR_W(9), .MEM_BYTES(512)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .byte_in   (byte_in),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_we === 1'b1) we_count++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic rdy, input logic we,
                              input logic [8:0] addr, input logic [31:0] data,
                              input logic hold, input logic dn, input logic er);
        check({tag, ".byte_ready"}, 32'(byte_ready), 32'(rdy));
        check({tag, ".mem_we"},     32'(mem_we),     32'(we));
        check({tag, ".mem_addr"},   32'(mem_addr),   32'(addr));
        check({tag, ".mem_data"},   mem_data,        data);
        check({tag, ".cpu_hold"},   32'(cpu_hold),   32'(hold));
        check({tag, ".done"},       32'(done),       32'(dn));
        check({tag, ".error"},      32'(error),      32'(er));
    endtask

    task automatic drive(input logic s, input logic v, input logic [7:0] b);
        start      = s;
        byte_valid = v;
        byte_in    = b;
        @(negedge clk);
    endtask

    task automatic add(input logic s, input logic v, input logic [7:0] b,
                       input logic rdy, input logic we, input logic [8:0] addr,
                       input logic [31:0] data, input logic hold, input logic dn,
                       input logic er);
        vec_t r;
        r.st = s; r.vl = v; r.b = b; r.rdy = rdy; r.we = we; r.addr = addr;
        r.data = data; r.hold = hold; r.dn = dn; r.er = er;
        vecs.push_back(r);
    endtask

    initial begin
        int base;
        logic [7:0] partial [6];

        repeat (2) @(negedge clk);
        check_outs("reset", 0, 0, 9'h0, 32'h0, 1, 0, 0);
        reset = 1'b1;

        // Each row: inputs applied this cycle, outputs expected before the edge.
        add(0, 1, 8'h55, 0, 0, 9'h0, 32'h0, 1, 0, 0);          // IDLE ignores valid
        add(1, 0, 8'h00, 0, 0, 9'h0, 32'h0, 1, 0, 0);          // IDLE + start
        add(0, 1, 8'h00, 1, 0, 9'h0, 32'h0, 1, 0, 0);          // LEN_HI
        add(0, 1, 8'h02, 1, 0, 9'h0, 32'h0, 1, 0, 0);          // LEN_LO, N=2
        add(0, 1, 8'h8C, 1, 0, 9'h0, 32'h0, 1, 0, 0);
        add(0, 1, 8'h01, 1, 0, 9'h0, 32'h0, 1, 0, 0);
        add(0, 1, 8'h00, 1, 0, 9'h0, 32'h0, 1, 0, 0);
        add(0, 1, 8'h04, 1, 0, 9'h0, 32'h0, 1, 0, 0);
        add(0, 1, 8'h00, 1, 1, 9'h0, 32'h8C010004, 1, 0, 0);   // first write
        add(0, 1, 8'h22, 1, 0, 9'h4, 32'h8C010004, 1, 0, 0);
        add(0, 1, 8'h18, 1, 0, 9'h4, 32'h8C010004, 1, 0, 0);
        add(0, 1, 8'h20, 1, 0, 9'h4, 32'h8C010004, 1, 0, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        add(0, 1, 8'h93, 1, 1, 9'h4, 32'h00221820, 1, 0, 0);   // CHECK + last write
        add(1, 0, 8'h00, 0, 0, 9'h8, 32'h00221820, 0, 1, 0);   // DONE + start
`else
        add(0, 0, 8'h00, 0, 1, 9'h4, 32'h00221820, 0, 1, 0);   // DONE + last write
        add(1, 0, 8'h00, 0, 0, 9'h8, 32'h00221820, 0, 1, 0);   // DONE + start
`endif
        add(0, 1, 8'h00, 1, 0, 9'h0, 32'h00221820, 1, 0, 0);   // LEN_HI, addr cleared
        add(0, 1, 8'h00, 1, 0, 9'h0, 32'h00221820, 1, 0, 0);   // LEN_LO, N=0
        add(0, 0, 8'h00, 0, 0, 9'h0, 32'h00221820, 0, 1, 0);   // DONE, no write
        add(1, 1, 8'h00, 0, 0, 9'h0, 32'h00221820, 0, 1, 0);   // DONE + start
        add(0, 1, 8'h00, 1, 0, 9'h0, 32'h00221820, 1, 0, 0);   // LEN_HI
        add(0, 1, 8'h81, 1, 0, 9'h0, 32'h00221820, 1, 0, 0);   // LEN_LO, N=129
        add(0, 1, 8'h77, 0, 0, 9'h0, 32'h00221820, 1, 0, 1);   // ERROR ignores valid
        add(0, 0, 8'h00, 0, 0, 9'h0, 32'h00221820, 1, 0, 1);

        base = we_count;
        for (int i = 0; i < vecs.size(); i++) begin
            check_outs($sformatf("vec%0d", i), vecs[i].rdy, vecs[i].we, vecs[i].addr,
                       vecs[i].data, vecs[i].hold, vecs[i].dn, vecs[i].er);
            drive(vecs[i].st, vecs[i].vl, vecs[i].b);
        end
        check("table.write_count", 32'(we_count - base), 32'd2);

        // N=1 with a 5-cycle stall between payload bytes 2 and 3; start pulses ignored.
        base = we_count;
        drive(1, 0, 8'h00);
        check("stall.ready_after_start", 32'(byte_ready), 32'd1);
        check("stall.error_cleared", 32'(error), 32'd0);
        drive(0, 1, 8'h00);
        drive(0, 1, 8'h01);
        drive(0, 1, 8'h12);
        drive(0, 1, 8'h34);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall%0d.mem_we", i), 32'(mem_we), 32'd0);
            check($sformatf("stall%0d.byte_ready", i), 32'(byte_ready), 32'd1);
            drive(1, 0, 8'h00);
        end
        drive(0, 1, 8'h56);
        check("stall.no_early_we", 32'(mem_we), 32'd0);
        drive(0, 1, 8'h78);
        check("stall.mem_we", 32'(mem_we), 32'd1);
        check("stall.mem_addr", 32'(mem_addr), 32'h0);
        check("stall.mem_data", mem_data, 32'h12345678);
`ifdef IMEM_LOADER_CHECKSUM_EN
        drive(0, 1, 8'h08);
`endif
        check("stall.done", 32'(done), 32'd1);
        check("stall.cpu_hold", 32'(cpu_hold), 32'd0);
        drive(0, 0, 8'h00);
        check("stall.write_count", 32'(we_count - base), 32'd1);

        // Reset after 6 payload bytes, then a fresh load restarting at address 0.
        base = we_count;
        partial = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
        drive(1, 0, 8'h00);
        drive(0, 1, 8'h00);
        drive(0, 1, 8'h02);
        for (int i = 0; i < 6; i++) drive(0, 1, partial[i]);
        check("midreset.addr_advanced", 32'(mem_addr), 32'h4);
        reset = 1'b0;
        drive(0, 0, 8'h00);
        check_outs("midreset", 0, 0, 9'h0, 32'h0, 1, 0, 0);
        reset = 1'b1;
        check("midreset.write_count", 32'(we_count - base), 32'd1);
        drive(1, 0, 8'h00);
        check("reload.ready", 32'(byte_ready), 32'd1);
        drive(0, 1, 8'h00);
        drive(0, 1, 8'h01);
        drive(0, 1, 8'h11);
        drive(0, 1, 8'h22);
        drive(0, 1, 8'h33);
        drive(0, 1, 8'h44);
        check("reload.mem_we", 32'(mem_we), 32'd1);
        check("reload.mem_addr", 32'(mem_addr), 32'h0);
        check("reload.mem_data", mem_data, 32'h11223344);
`ifdef IMEM_LOADER_CHECKSUM_EN
        drive(0, 1, 8'h44);
`endif
        check("reload.done", 32'(done), 32'd1);
        check("reload.cpu_hold", 32'(cpu_hold), 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum of 01 02 03 04 is 04: good then bad trailer.
        drive(1, 0, 8'h00);
        drive(0, 1, 8'h00);
        drive(0, 1, 8'h01);
        drive(0, 1, 8'h01);
        drive(0, 1, 8'h02);
        drive(0, 1, 8'h03);
        drive(0, 1, 8'h04);
        drive(0, 1, 8'h04);
        check("csum_ok.done", 32'(done), 32'd1);
        check("csum_ok.error", 32'(error), 32'd0);
        drive(1, 0, 8'h00);
        drive(0, 1, 8'h00);
        drive(0, 1, 8'h01);
        drive(0, 1, 8'h01);
        drive(0, 1, 8'h02);
        drive(0, 1, 8'h03);
        drive(0, 1, 8'h04);
        drive(0, 1, 8'h05);
        check("csum_bad.error", 32'(error), 32'd1);
        check("csum_bad.done", 32'(done), 32'd0);
        check("csum_bad.cpu_hold", 32'(cpu_hold), 32'd1);
`endif

        drive(0, 0, 8'h00);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader for the pipelined MIPS core: receives a length-prefixed byte stream over a valid/ready handshake, packs it big-endian into 32-bit words and writes them into instruction memory through its write port. It holds the pipeline (PC/NPC and all stage registers) while loading and releases it only after a complete, valid image is written. It replaces file-based preloading of instruction memory in hardware builds.

## Interface
- `ADDR_W`, 9: instruction-memory byte-address width.
- `MEM_BYTES`, 512: instruction-memory capacity in bytes; the maximum image is MEM_BYTES/4 words.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-low reset; sampled on the rising edge of `clk`.
- `start`  in  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERROR.
- `byte_in`  in  8  stream byte.
- `byte_valid`  in  1  `byte_in` is valid.
- `byte_ready`  out  1  loader accepts a byte this cycle.
- `mem_we`  out  1  one-cycle word-write strobe to instruction memory.
- `mem_addr`  out  ADDR_W  word-aligned byte address; bits [1:0] are always 0.
- `mem_data`  out  32  word to write; the first stream byte of the word is in bits [31:24].
- `cpu_hold`  out  1  active-high hold/reset to the pipeline.
- `done`  out  1  image loaded; level signal.
- `error`  out  1  load rejected; level signal.

## Operation
- A byte is transferred when `byte_valid && byte_ready` on a rising edge.
- Stream format:
  - LEN_HI byte, then LEN_LO byte, forming a 16-bit word count N.
  - Then 4·N payload bytes.
  - With checksum enabled, one final checksum byte follows the payload.
- FSM states and transitions:
  - IDLE: waits for `start`, then goes to LEN_HI.
  - LEN_HI: accepts one byte, then goes to LEN_LO.
  - LEN_LO: accepts one byte, then branches:
    - N = 0: go to DONE.
    - N > MEM_BYTES/4: go to ERROR.
    - Otherwise: go to LOAD.
  - LOAD: accepts 4·N bytes, then goes to CHECK (checksum enabled) or DONE.
  - CHECK: accepts one byte, then goes to DONE or ERROR.
  - DONE and ERROR: wait for `start`, then go to LEN_HI.
- `byte_ready` is 1 in LEN_HI, LEN_LO, LOAD and CHECK, and 0 elsewhere.
- Word packing:
  - A 2-bit byte counter shifts bytes in MSB-first.
  - On the 4th accepted byte, the word is registered to `mem_data` and `mem_we` pulses.
  - The address counter starts at 0 for each load and advances by 4 after every write.
  - The address never wraps, because N is bounded by MEM_BYTES/4.
- `cpu_hold` is 1 in every state except DONE.
- `done` is 1 only in DONE; `error` is 1 only in ERROR. They are never high together.
- `start` is ignored in LEN_HI, LEN_LO, LOAD and CHECK.
- A `start` in DONE or ERROR clears `done`/`error` and raises `cpu_hold` on the next cycle.
- `byte_valid` outside the ready states is ignored and no data is consumed.

## Timing
- Reset values: state IDLE, `byte_ready` 0, `mem_we` 0, `mem_addr` 0, `mem_data` 0, `cpu_hold` 1, `done` 0, `error` 0.
- `byte_ready` goes high the cycle after `start` is sampled.
- `mem_we` is high for exactly the cycle after the edge that accepted the 4th byte of a word, with `mem_addr`/`mem_data` stable in that cycle.
- Back-to-back words: full throughput of one byte per cycle, so one write every 4 cycles. The write and the next byte acceptance overlap without stall.
- After the last payload byte (or the checksum byte): DONE, with `cpu_hold` low, is entered on the next edge. The last `mem_we` is in the same cycle DONE is entered.
- Stalls (`byte_valid` low) pause all counters indefinitely; there is no timeout.
- Reset mid-load aborts immediately to reset values. Words already written remain in memory; `cpu_hold` stays 1 until a later successful load.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - The CHECK state exists.
  - A running XOR of all payload bytes is compared with the checksum byte.
  - On mismatch, go to ERROR; `cpu_hold` stays 1. Written words are not rolled back.
- Undefined:
  - No CHECK state and no checksum byte expected.
  - LOAD goes straight to DONE.

## Structure
- `imem_loader_pkg` holds:
  - the state enum (IDLE, LEN_HI, LEN_LO, LOAD, CHECK, DONE, ERROR);
  - the `MEM_BYTES` default;
  - the `MAX_WORDS` = MEM_BYTES/4 constant.
- Sub-module `byte_packer`: byte shift register, 2-bit counter and word-complete strobe. The top FSM owns the addressing, the word count and the handshake.

## Test plan
- N=2, bytes 8C 01 00 04 / 00 22 18 20 streamed continuously:
  - `mem_we` pulses twice: addr 0 with 8C010004, then addr 4 with 00221820;
  - `done`=1 and `cpu_hold`=0 after the last byte.
- N=0 (header 00 00): DONE on the edge after LEN_LO; no `mem_we`.
- N=0x0081 (129 > 128): ERROR after LEN_LO; `byte_ready`=0, `cpu_hold`=1, no writes.
- N=1 with `byte_valid` dropped for 5 cycles between bytes 2 and 3: single write of the correct word at addr 0; no extra or early `mem_we`.
- Reset asserted after 6 payload bytes: all outputs return to reset values next edge. A fresh load then restarts at addr 0.
- Checksum build, N=1, payload 01 02 03 04:
  - checksum 04: DONE;
  - checksum 05: ERROR with `cpu_hold`=1.
